fifo_uart_tx_module: RTL and testbench

Drains the transmit FIFO and serialises each byte onto the UART TX pin as an 8N1 frame (optionally 8E1). Sits directly downstream of the TX FIFO that the loopback/inter-control stage writes into. It pops one byte at a time through the FIFO's read-request/empty handshake and holds the line idle-high between frames. Bit timing comes from a parameterised per-bit clock count.

---
 rtl/fifo_uart_tx_module.sv | 129 ++++++++++++
 tb/tb_fifo_uart_tx_module.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_module.sv
// fifo_uart_tx_module: pops bytes from the TX FIFO and shifts each out as a UART frame, LSB first.
// Define TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit (8E1); default build is 8N1.
module fifo_uart_tx_module #(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Empty_Sig,
    input  logic [7:0] FIFO_Read_Data,
    output logic       Read_Req_Sig,
    output logic       TX_Pin_Out,
    output logic       TX_Busy_Sig
);

`ifdef TX_PARITY_EN
    localparam int unsigned FRAME_LEN = 11;
`else
    localparam int unsigned FRAME_LEN = 10;
`endif
    localparam logic [15:0] BAUD_LAST = 16'(BPS_CNT - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] baud_q;
    logic [3:0]  bit_idx_q;
    logic [7:0]  data_q;
    logic [10:0] frame_q;
    logic [10:0] frame_d;
    logic        req_q;
    logic        tx_q;
    logic        busy_q;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // Bit 0 is the start bit; the unused top bit in 8N1 is a second stop-level bit that is never sent.
    function automatic logic [10:0] build_frame(input logic [7:0] d);
`ifdef TX_PARITY_EN
        return {1'b1, even_parity(d), d, 1'b0};
`else
        return {1'b1, 1'b1, d, 1'b0};
`endif
    endfunction

    // Frame image of the captured byte, consumed in LOAD
    always_comb begin
        frame_d = build_frame(data_q);
    end

    // Transmit FSM: pop handshake, frame load and per-bit baud timing
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 4'd0;
            data_q    <= 8'd0;
            frame_q   <= 11'h7FF;
            req_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    req_q <= 1'b0;
                    if (!Empty_Sig) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_REQ: begin
                    req_q   <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    data_q  <= FIFO_Read_Data;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    // frame_q holds the bits still to come; the start bit goes straight to the pin
                    tx_q      <= frame_d[0];
                    frame_q   <= {1'b1, frame_d[10:1]};
                    baud_q    <= 16'd0;
                    bit_idx_q <= 4'd0;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= 16'd0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            tx_q      <= frame_q[0];
                            frame_q   <= {1'b1, frame_q[10:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Read_Req_Sig = req_q;
    assign TX_Pin_Out   = tx_q;
    assign TX_Busy_Sig  = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx_module.sv
// Randomised bench for fifo_uart_tx_module: two instances (4 and 2 clocks per bit) checked cycle by cycle
// against a frame-level reference model fed from a queue-based FIFO.
module tb_fifo_uart_tx_module;

    localparam int BPS0 = 4;
    localparam int BPS1 = 2;
`ifdef TX_PARITY_EN
    localparam int LEN = 11;
`else
    localparam int LEN = 10;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] empty_s;
    logic [7:0] data_s [2];
    wire  [1:0] req_s;
    wire  [1:0] tx_s;
    wire  [1:0] busy_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_uart_tx_module #(.BPS_CNT(BPS0)) u_dut0 (
        .CLK(clk), .RST(rst), .Empty_Sig(empty_s[0]), .FIFO_Read_Data(data_s[0]),
        .Read_Req_Sig(req_s[0]), .TX_Pin_Out(tx_s[0]), .TX_Busy_Sig(busy_s[0])
    );

    fifo_uart_tx_module #(.BPS_CNT(BPS1)) u_dut1 (
        .CLK(clk), .RST(rst), .Empty_Sig(empty_s[1]), .FIFO_Read_Data(data_s[1]),
        .Read_Req_Sig(req_s[1]), .TX_Pin_Out(tx_s[1]), .TX_Busy_Sig(busy_s[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame position p (0 = start bit) for byte b
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
`ifdef TX_PARITY_EN
        if (p == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Expected outputs k cycles after IDLE first sees a non-empty FIFO holding all of b
    task automatic model(input byte_q_t b, input int bps, input int k,
                         output logic tx, output logic busy, output logic req);
        int k0;
        int span;
        k0   = 0;
        span = 4 + LEN * bps;
        tx   = 1'b1;
        busy = 1'b0;
        req  = 1'b0;
        foreach (b[i]) begin
            if (k >= k0 && k < k0 + span) begin
                if (k > k0)      busy = 1'b1;
                if (k == k0 + 1) req  = 1'b1;
                if (k >= k0 + 4) tx   = frame_bit(b[i], (k - k0 - 4) / bps);
            end
            k0 += span;
        end
    endtask

    // Load the FIFO with b at k=0 and compare every cycle; optionally pulse reset at cycle reset_k
    task automatic run_scn(input int d, input byte_q_t b, input int reset_k, input string name);
        int         bps;
        int         ncyc;
        logic [7:0] fifo_q[$];
        logic       pend;
        logic       et, eb, er;
        bit         after_rst;
        bps       = (d == 0) ? BPS0 : BPS1;
        ncyc      = (b.size() == 0) ? 1000 : b.size() * (4 + LEN * bps) + 6;
        after_rst = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (after_rst) begin
                et = 1'b1; eb = 1'b0; er = 1'b0;
            end else begin
                model(b, bps, k, et, eb, er);
            end
            check_eq($sformatf("%s/d%0d/tx@%0d", name, d, k), {31'd0, tx_s[d]}, {31'd0, et});
            check_eq($sformatf("%s/d%0d/busy@%0d", name, d, k), {31'd0, busy_s[d]}, {31'd0, eb});
            check_eq($sformatf("%s/d%0d/req@%0d", name, d, k), {31'd0, req_s[d]}, {31'd0, er});
            pend = req_s[d];
            if (pend) check_eq($sformatf("%s/d%0d/pop_nonempty@%0d", name, d, k),
                               {31'd0, fifo_q.size() > 0}, 32'd1);
            if (k == 0) begin
                foreach (b[i]) fifo_q.push_back(b[i]);
                empty_s[d] = (fifo_q.size() == 0);
            end
            rst = (k == reset_k);
            if (k == reset_k) after_rst = 1'b1;
            @(posedge clk);
            #1;
            if (pend && fifo_q.size() > 0) data_s[d] = fifo_q.pop_front();
            empty_s[d] = (fifo_q.size() == 0);
        end
        rst = 1'b0;
        check_eq($sformatf("%s/d%0d/fifo_drained", name, d), fifo_q.size(), 32'd0);
    endtask

    initial begin
        byte_q_t q;
        int      d;
        int      n;
        rst       = 1'b1;
        empty_s   = 2'b11;
        data_s[0] = 8'h00;
        data_s[1] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("reset/d%0d/tx", i), {31'd0, tx_s[i]}, 32'd1);
            check_eq($sformatf("reset/d%0d/busy", i), {31'd0, busy_s[i]}, 32'd0);
            check_eq($sformatf("reset/d%0d/req", i), {31'd0, req_s[i]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        q = '{8'h55};               run_scn(0, q, -1, "single55");
        q = '{};                    run_scn(0, q, -1, "empty1000");
        q = '{8'hA5, 8'h3C};        run_scn(0, q, -1, "b2b");
        q = '{8'h00};               run_scn(0, q, 4 + 4 * BPS0 + 1, "rst_d3");
        q = '{};                    run_scn(0, q, -1, "post_rst_idle");
        q = '{8'h07, 8'h03};        run_scn(0, q, -1, "parity");
        q = '{8'hFF};               run_scn(1, q, -1, "ff_bps2");
        q = '{8'h00, 8'h80, 8'h01}; run_scn(1, q, -1, "edges_bps2");

        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 1);
            n = $urandom_range(1, 3);
            q = '{};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            run_scn(d, q, -1, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
